// File: rtl/rtc_sonar_sequencer.sv
// Avalon-MM master that runs one ultrasonic time-of-flight measurement per start
// request against the realtime-clock slave and reports the wrap-aware echo delay.
module rtc_sonar_sequencer #(
    parameter int unsigned PULSE_CYCLES   = 500,
    parameter int unsigned POLL_GAP       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [15:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        result_valid,
    output logic        timeout,
    output logic [31:0] tx_time,
    output logic [31:0] rx_time,
    output logic [31:0] tof
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned HOLD_W = 16;
    localparam int unsigned GAP_W  = 8;

    localparam logic [ADDR_W-1:0] ADDR_TRIG = 16'h0100;
    localparam logic [ADDR_W-1:0] ADDR_TX   = 16'h0200;
    localparam logic [ADDR_W-1:0] ADDR_FIRE = 16'h0300;

    localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(PULSE_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD    = GAP_W'(POLL_GAP);
    localparam logic [DATA_W-1:0] TIMEOUT_LIM = DATA_W'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        S_IDLE,
        S_BASE,
        S_ARM,
        S_FIRE,
        S_HOLD,
        S_RELEASE,
        S_READ_TX,
        S_POLL,
        S_GAP,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                rvalid_q, rvalid_d;
    logic                tmo_q, tmo_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   tof_q, tof_d;
    logic [DATA_W-1:0]   baseline_q, baseline_d;
    logic [DATA_W-1:0]   tx_cap_q, tx_cap_d;
    logic [DATA_W-1:0]   timer_q, timer_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

    logic                xfer_done_c;
    logic                tmo_hit_c;
    logic                fin_echo;
    logic                fin_tmo;
    logic [DATA_W-1:0]   fin_tx;

    assign xfer_done_c = (rd_q | wr_q) & ~avm_waitrequest;
    assign tmo_hit_c   = (timer_q >= TIMEOUT_LIM);

    // Next-state, bus strobes and result latching
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        rvalid_d   = 1'b0;
        tmo_d      = tmo_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        tof_d      = tof_q;
        baseline_d = baseline_q;
        tx_cap_d   = tx_cap_q;
        timer_d    = tmo_hit_c ? timer_q : timer_q + 32'd1;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        fin_echo   = 1'b0;
        fin_tmo    = 1'b0;
        fin_tx     = tx_cap_q;

        // A bus state holds its strobe until completion, then idles one cycle with
        // the strobe low before the next state issues its own transfer.
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_BASE;
                    rd_d    = 1'b1;
                    addr_d  = ADDR_TRIG;
                    busy_d  = 1'b1;
                end
            end
            S_BASE: begin
                if (rd_q) begin
                    if (xfer_done_c) begin
                        rd_d       = 1'b0;
                        baseline_d = avm_readdata;
                    end
                end else begin
                    state_d = S_ARM;
                    wr_d    = 1'b1;
                    addr_d  = ADDR_TX;
                    wdata_d = 32'd1;
                end
            end
            S_ARM: begin
                if (wr_q) begin
                    if (xfer_done_c) wr_d = 1'b0;
                end else begin
                    state_d = S_FIRE;
                    wr_d    = 1'b1;
                    addr_d  = ADDR_FIRE;
                    wdata_d = 32'd1;
                end
            end
            S_FIRE: begin
                if (wr_q) begin
                    if (xfer_done_c) begin
                        wr_d    = 1'b0;
                        // counter reads 0 in the completion cycle itself
                        timer_d = 32'd1;
                    end
                end else begin
                    state_d    = S_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = S_RELEASE;
                    wr_d    = 1'b1;
                    addr_d  = ADDR_FIRE;
                    wdata_d = 32'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q - 16'd1;
                end
            end
            S_RELEASE: begin
                if (wr_q) begin
                    if (xfer_done_c) wr_d = 1'b0;
                end else begin
                    state_d = S_READ_TX;
                    rd_d    = 1'b1;
                    addr_d  = ADDR_TX;
                end
            end
            S_READ_TX: begin
                if (rd_q) begin
                    if (xfer_done_c) begin
                        rd_d     = 1'b0;
                        tx_cap_d = avm_readdata;
                        fin_tx   = avm_readdata;
                        fin_tmo  = tmo_hit_c;
                    end
                end else begin
                    state_d = S_POLL;
                    rd_d    = 1'b1;
                    addr_d  = ADDR_TRIG;
                end
            end
            S_POLL: begin
                if (xfer_done_c) begin
                    rd_d = 1'b0;
                    if (avm_readdata != baseline_q) begin
                        fin_echo = 1'b1;
                    end else if (tmo_hit_c) begin
                        fin_tmo = 1'b1;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = GAP_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (tmo_hit_c) begin
                    fin_tmo = 1'b1;
                end else if (gap_cnt_q == '0) begin
                    state_d = S_POLL;
                    rd_d    = 1'b1;
                    addr_d  = ADDR_TRIG;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fin_echo || fin_tmo) begin
            state_d  = S_DONE;
            rd_d     = 1'b0;
            wr_d     = 1'b0;
            busy_d   = 1'b0;
            rvalid_d = 1'b1;
            tx_d     = fin_tx;
            tmo_d    = ~fin_echo;
            rx_d     = fin_echo ? avm_readdata : 32'd0;
            tof_d    = fin_echo ? (avm_readdata - fin_tx) : 32'd0;
        end
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            tmo_q      <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            tof_q      <= '0;
            baseline_q <= '0;
            tx_cap_q   <= '0;
            timer_q    <= '0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            rvalid_q   <= rvalid_d;
            tmo_q      <= tmo_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            tof_q      <= tof_d;
            baseline_q <= baseline_d;
            tx_cap_q   <= tx_cap_d;
            timer_q    <= timer_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign avm_address   = addr_q;
    assign avm_read      = rd_q;
    assign avm_write     = wr_q;
    assign avm_writedata = wdata_q;
    assign busy          = busy_q;
    assign result_valid  = rvalid_q;
    assign timeout       = tmo_q;
    assign tx_time       = tx_q;
    assign rx_time       = rx_q;
    assign tof           = tof_q;

endmodule
